// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS instruction/data memories: reset vector,
// NOP encoding, loader FSM states and the bus byte-swap helper.
package mips_mem_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD     = 32'h00000000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERR     = 3'd4
  } loader_state_t;

  // Reverse byte order: assembled big-endian word -> core bus order.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mips_instr_rom_array.sv
// Instruction storage: DEPTH_WORDS x 32 words plus a per-word valid bitmap.
// One synchronous write port, one asynchronous read port and a synchronous
// clear that wipes the bitmap (contents stay, but are masked as unwritten).
module mips_instr_rom_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  output logic          rd_valid_o
);

  logic [31:0]            mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] valid_q;

  // Word storage; needs no reset because the valid bitmap masks stale data.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Valid bitmap: clear-all has priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= {DEPTH_WORDS{1'b0}};
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/mips_instr_loader_mem.sv
// Loadable instruction memory for the Harvard MIPS core. A host streams the
// program image in while the core is held in reset; after the last word the
// core is released and fetches are served combinationally, byte-swapped.
module mips_instr_loader_mem
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          AW          = $clog2(DEPTH_WORDS),
  parameter int          CW          = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic [CW-1:0] load_count,
  output logic          cpu_reset,
  output logic          load_overflow,
  input  logic [31:0]   instr_address,
  output logic [31:0]   instr_readdata
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH_WORDS);
  localparam logic [31:0]   SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  loader_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          cpu_rst_q;

  logic          accept_s;
  logic          wr_en_s;
  logic          clr_s;
  logic [31:0]   off_s;
  logic          hit_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0]   rd_data_s;
  logic          rd_valid_s;

  // Ready depends only on registered state so the host sees no comb path.
  assign load_ready = (state_q == LOAD) && (count_q < FULL_COUNT);
  assign accept_s   = load_valid && load_ready;

  // A restart (or reset) drops any word offered in the same cycle.
  assign wr_en_s = accept_s && !load_start && !reset;
  assign clr_s   = reset || load_start;

  // Loader FSM next-state, counter and overflow flag.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load_start) begin
      state_d = LOAD;
      count_d = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: begin
          if (accept_s) begin
            count_d = count_q + CW'(1);
            if (load_last) begin
              state_d = RELEASE;
            end else begin
              state_d = LOAD;
            end
          end else if (load_valid && (count_q == FULL_COUNT)) begin
            ovf_d   = 1'b1;
            state_d = ERR;
          end else begin
            state_d = LOAD;
          end
        end
        RELEASE: state_d = RUN;
        RUN:     state_d = RUN;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; cpu_reset is registered from the next state so it
  // drops on the very edge that enters RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= {CW{1'b0}};
      ovf_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cpu_rst_q <= (state_d != RUN);
    end
  end

  assign load_count    = count_q;
  assign load_overflow = ovf_q;
  assign cpu_reset     = cpu_rst_q;

  // Address decode: offset from the reset vector, wrapping modulo 2^32 so
  // anything below BASE_ADDR lands far out of range.
  always_comb begin
    off_s    = instr_address - BASE_ADDR;
    hit_s    = (off_s[1:0] == 2'b00) && (off_s < SPAN_BYTES);
    rd_idx_s = off_s[AW+1:2];
  end

  mips_instr_rom_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk        (clk),
    .clr_i      (clr_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (count_q[AW-1:0]),
    .wr_data_i  (load_data),
    .rd_idx_i   (rd_idx_s),
    .rd_data_o  (rd_data_s),
    .rd_valid_o (rd_valid_s)
  );

  // Fetch data: unaligned, out-of-range or unwritten words read as NOP.
  always_comb begin
    if (hit_s && rd_valid_s) begin
      instr_readdata = bswap32(rd_data_s);
    end else begin
      instr_readdata = NOP_WORD;
    end
  end

endmodule

// File: tb/tb_mips_instr_loader_mem.sv
// Scoreboard bench for mips_instr_loader_mem. Instance 0 uses 256 words,
// instance 1 uses 4 words for the full/overflow cases.
module tb_mips_instr_loader_mem;

  localparam int K_RDATA = 0;
  localparam int K_COUNT = 1;
  localparam int K_CPURST = 2;
  localparam int K_READY = 3;
  localparam int K_OVF = 4;
  localparam int K_TIMEOUT = 5;

  typedef struct {
    int          sel;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  logic        clk = 1'b0;
  logic        rst[2];
  logic        st[2];
  logic        vld[2];
  logic        lst[2];
  logic [31:0] dat[2];
  logic [31:0] addr[2];
  logic        rdy[2];
  logic        cpur[2];
  logic        ovf[2];
  logic [31:0] rdata[2];
  logic [8:0]  count_a;
  logic [2:0]  count_b;

  always #5 clk = ~clk;

  mips_instr_loader_mem #(.DEPTH_WORDS(256)) dut_a (
    .clk(clk), .reset(rst[0]), .load_start(st[0]), .load_valid(vld[0]),
    .load_ready(rdy[0]), .load_data(dat[0]), .load_last(lst[0]),
    .load_count(count_a), .cpu_reset(cpur[0]), .load_overflow(ovf[0]),
    .instr_address(addr[0]), .instr_readdata(rdata[0])
  );

  mips_instr_loader_mem #(.DEPTH_WORDS(4)) dut_b (
    .clk(clk), .reset(rst[1]), .load_start(st[1]), .load_valid(vld[1]),
    .load_ready(rdy[1]), .load_data(dat[1]), .load_last(lst[1]),
    .load_count(count_b), .cpu_reset(cpur[1]), .load_overflow(ovf[1]),
    .instr_address(addr[1]), .instr_readdata(rdata[1])
  );

  // Monitor: on each falling edge, drain pending expectations and compare.
  always @(negedge clk) begin
    chk_t        it;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        K_RDATA:  act = rdata[it.sel];
        K_COUNT:  act = (it.sel == 0) ? 32'(count_a) : 32'(count_b);
        K_CPURST: act = 32'(cpur[it.sel]);
        K_READY:  act = 32'(rdy[it.sel]);
        K_OVF:    act = 32'(ovf[it.sel]);
        default:  act = 32'h0;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s (dut%0d): got %h want %h", it.name, it.sel, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int sel, input int kind, input logic [31:0] exp, input string name);
    chk_t it;
    it.sel = sel; it.kind = kind; it.exp = exp; it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic fetch(input int sel, input logic [31:0] a, input logic [31:0] exp, input string name);
    addr[sel] = a;
    expect_v(sel, K_RDATA, exp, name);
    tick();
  endtask

  task automatic do_reset(input int sel);
    rst[sel] = 1'b1;
    tick();
    rst[sel] = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    st[sel] = 1'b1;
    tick();
    st[sel] = 1'b0;
  endtask

  // Offer one word until accepted; optionally toggle valid randomly.
  task automatic send(input int sel, input logic [31:0] d, input logic last, input bit rnd);
    bit done = 1'b0;
    dat[sel] = d;
    lst[sel] = last;
    for (int i = 0; i < 50 && !done; i++) begin
      vld[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld[sel] && rdy[sel]) done = 1'b1;
      tick();
    end
    vld[sel] = 1'b0;
    lst[sel] = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout (dut%0d): word %h not accepted within 50 cycles", sel, d);
    end
  endtask

  logic [31:0] img1 [5] = '{32'h2484000B, 32'h24A5004D, 32'h01490823, 32'h00000008, 32'h24000000};
  logic [31:0] img6 [4] = '{32'h11223344, 32'hA1B2C3D4, 32'h0000FFFF, 32'h8000_0001};
  logic [31:0] swp6 [4] = '{32'h44332211, 32'hD4C3B2A1, 32'hFFFF0000, 32'h0100_0080};

  // Load the five-word test image into instance 0 and check release timing.
  task automatic load_img1(input string tag);
    pulse_start(0);
    expect_v(0, K_READY, 32'h1, {tag, "_ready_load"});
    expect_v(0, K_COUNT, 32'h0, {tag, "_count_start"});
    for (int i = 0; i < 5; i++) send(0, img1[i], (i == 4), 1'b0);
    expect_v(0, K_COUNT, 32'h5, {tag, "_count5"});
    expect_v(0, K_CPURST, 32'h1, {tag, "_cpurst_release"});
    fetch(0, 32'hBFC00000, 32'h0B008424, {tag, "_fetch0"});
    expect_v(0, K_CPURST, 32'h0, {tag, "_cpurst_run"});
    fetch(0, 32'hBFC00004, 32'h4D00A524, {tag, "_fetch4"});
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; st[s] = 1'b0; vld[s] = 1'b0; lst[s] = 1'b0;
      dat[s] = 32'h0; addr[s] = 32'h0;
    end
    tick();

    // Test 1: reset values, then load the image.
    do_reset(0);
    total++;
    if (cpur[0] !== 1'b1 || rdy[0] !== 1'b0 || count_a !== 9'd0 || ovf[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_state (dut0): cpu_reset=%b ready=%b count=%0d ovf=%b",
               cpur[0], rdy[0], count_a, ovf[0]);
    end
    expect_v(0, K_CPURST, 32'h1, "rst_cpurst");
    expect_v(0, K_READY, 32'h0, "rst_ready");
    expect_v(0, K_COUNT, 32'h0, "rst_count");
    expect_v(0, K_OVF, 32'h0, "rst_ovf");
    tick();
    load_img1("t1");

    // Test 2: NOP for low, below-base, unaligned and unwritten addresses.
    fetch(0, 32'h00000000, 32'h0, "t2_addr0");
    fetch(0, 32'hBFBFFFFC, 32'h0, "t2_below_base");
    fetch(0, 32'hBFC00002, 32'h0, "t2_unaligned");
    fetch(0, 32'hBFC00014, 32'h0, "t2_unwritten");
    fetch(0, 32'hBFC00010, 32'h00000024, "t2_word4");

    // Test 3: overflow on the 4-word instance.
    do_reset(1);
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(1, img6[i], 1'b0, 1'b0);
    expect_v(1, K_READY, 32'h0, "t3_ready_full");
    expect_v(1, K_COUNT, 32'h4, "t3_count_full");
    expect_v(1, K_OVF, 32'h0, "t3_no_ovf_yet");
    vld[1] = 1'b1; dat[1] = 32'hDEADBEEF;
    tick();
    vld[1] = 1'b0;
    expect_v(1, K_OVF, 32'h1, "t3_ovf");
    expect_v(1, K_CPURST, 32'h1, "t3_cpurst_err");
    expect_v(1, K_READY, 32'h0, "t3_ready_err");
    tick();
    pulse_start(1);
    expect_v(1, K_OVF, 32'h1, "t3_ovf_sticky");
    expect_v(1, K_COUNT, 32'h0, "t3_count_restart");
    expect_v(1, K_READY, 32'h1, "t3_ready_restart");
    fetch(1, 32'hBFC00000, 32'h0, "t3_image_cleared");

    // Test 4: reset mid-load discards the partial image.
    do_reset(0);
    pulse_start(0);
    for (int i = 0; i < 3; i++) send(0, img1[i], 1'b0, 1'b0);
    expect_v(0, K_COUNT, 32'h3, "t4_count3");
    do_reset(0);
    expect_v(0, K_COUNT, 32'h0, "t4_count_rst");
    expect_v(0, K_CPURST, 32'h1, "t4_cpurst");
    fetch(0, 32'hBFC00000, 32'h0, "t4_fetch_cleared");
    load_img1("t4");

    // Test 5: restart from RUN and reload one word.
    pulse_start(0);
    expect_v(0, K_CPURST, 32'h1, "t5_cpurst_up");
    expect_v(0, K_COUNT, 32'h0, "t5_count0");
    fetch(0, 32'hBFC00004, 32'h0, "t5_old_word_gone");
    send(0, 32'h12345678, 1'b1, 1'b0);
    tick();
    expect_v(0, K_CPURST, 32'h0, "t5_cpurst_run");
    expect_v(0, K_COUNT, 32'h1, "t5_count1");
    fetch(0, 32'hBFC00000, 32'h78563412, "t5_new_word");

    // Test 6: random valid, image exactly fills the 4-word instance.
    do_reset(1);
    expect_v(1, K_OVF, 32'h0, "t6_ovf_cleared");
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(1, img6[i], (i == 3), 1'b1);
    expect_v(1, K_COUNT, 32'h4, "t6_count4");
    expect_v(1, K_OVF, 32'h0, "t6_no_ovf");
    expect_v(1, K_CPURST, 32'h1, "t6_cpurst_release");
    tick();
    expect_v(1, K_CPURST, 32'h0, "t6_cpurst_run");
    for (int i = 0; i < 4; i++) fetch(1, 32'hBFC00000 + 32'(4 * i), swp6[i], "t6_readback");
    fetch(1, 32'hBFC00010, 32'h0, "t6_past_end");

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
